// File: rtl/if_fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: default widths,
// fetch FSM encoding and the all-zeros bubble word.
package if_fetch_stage_pkg;

  localparam int DEF_ADDRESS_LEN     = 32;
  localparam int DEF_INSTRUCTION_LEN = 32;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_e;

  // A bubble presents zero PC and a zero instruction word with valid low.
  localparam logic [31:0] BUBBLE_WORD = 32'h0000_0000;

endpackage

// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register: loads a fetched word, holds under freeze,
// otherwise collapses to a bubble. Flush wins over everything.
module if_id_pipe_reg #(
  parameter int ADDRESS_LEN     = if_fetch_stage_pkg::DEF_ADDRESS_LEN,
  parameter int INSTRUCTION_LEN = if_fetch_stage_pkg::DEF_INSTRUCTION_LEN
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       load,
  input  logic                       hold,
  input  logic [ADDRESS_LEN-1:0]     load_pc,
  input  logic [INSTRUCTION_LEN-1:0] load_instr,
  output logic [ADDRESS_LEN-1:0]     pc,
  output logic [INSTRUCTION_LEN-1:0] instruction,
  output logic                       valid
);
  import if_fetch_stage_pkg::*;

  logic [ADDRESS_LEN-1:0]     pc_p1;
  logic [INSTRUCTION_LEN-1:0] instr_p1;
  logic                       vld_p1;

  // ---- stage p1: IF/ID boundary ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_p1    <= ADDRESS_LEN'(BUBBLE_WORD);
      instr_p1 <= INSTRUCTION_LEN'(BUBBLE_WORD);
      vld_p1   <= 1'b0;
    end else if (flush) begin
      pc_p1    <= ADDRESS_LEN'(BUBBLE_WORD);
      instr_p1 <= INSTRUCTION_LEN'(BUBBLE_WORD);
      vld_p1   <= 1'b0;
    end else if (load) begin
      pc_p1    <= load_pc;
      instr_p1 <= load_instr;
      vld_p1   <= 1'b1;
    end else if (!hold) begin
      pc_p1    <= ADDRESS_LEN'(BUBBLE_WORD);
      instr_p1 <= INSTRUCTION_LEN'(BUBBLE_WORD);
      vld_p1   <= 1'b0;
    end
  end

  assign pc          = pc_p1;
  assign instruction = instr_p1;
  assign valid       = vld_p1;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs a one-outstanding-request
// req/ack fetch to instruction memory, parks a word fetched under freeze,
// discards the in-flight word after a redirect, and feeds the IF/ID register.
module if_fetch_stage #(
  parameter int                     ADDRESS_LEN     = if_fetch_stage_pkg::DEF_ADDRESS_LEN,
  parameter int                     INSTRUCTION_LEN = if_fetch_stage_pkg::DEF_INSTRUCTION_LEN,
  parameter logic [ADDRESS_LEN-1:0] RESET_PC        = '0,
  parameter logic [ADDRESS_LEN-1:0] PC_STEP         = ADDRESS_LEN'(4)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       freeze,
  input  logic                       branch_taken,
  input  logic [ADDRESS_LEN-1:0]     branch_addr,
  output logic                       imem_req,
  output logic [ADDRESS_LEN-1:0]     imem_addr,
  input  logic                       imem_ack,
  input  logic [INSTRUCTION_LEN-1:0] imem_rdata,
  output logic [ADDRESS_LEN-1:0]     PC,
  output logic [INSTRUCTION_LEN-1:0] instruction,
  output logic                       valid,
  output logic [15:0]                bubble_count
);
  import if_fetch_stage_pkg::*;

  fetch_state_e               state, state_next;
  logic [ADDRESS_LEN-1:0]     pc_reg, pc_next, addr_reg;
  logic [INSTRUCTION_LEN-1:0] hold_buf, load_instr;
  logic                       req_reg, ack_q, hold_capture;
  logic                       flush, load, hold, vld_next;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Next-state, PC and IF/ID control; a redirect outranks freeze and ack.
  always_comb begin
    state_next   = state;
    pc_next      = pc_reg;
    flush        = 1'b0;
    load         = 1'b0;
    hold         = 1'b0;
    hold_capture = 1'b0;
    load_instr   = imem_rdata;
    // An ack only counts against a request we actually issued.
    ack_q        = imem_ack & req_reg;
    if (branch_taken) begin
      pc_next    = branch_addr;
      flush      = 1'b1;
      // A request still waiting for its ack must finish at the old address.
      // If the ack lands in this same cycle the request is done, so no discard.
      state_next = (req_reg && !imem_ack) ? DISCARD : FETCH;
    end else begin
      case (state)
        FETCH: begin
          if (ack_q && freeze) begin
            hold_capture = 1'b1;
            hold         = 1'b1;
            state_next   = HOLD;
          end else if (ack_q) begin
            load    = 1'b1;
            pc_next = pc_reg + PC_STEP;
          end else begin
            hold = freeze;
          end
        end
        HOLD: begin
          if (!freeze) begin
            load       = 1'b1;
            load_instr = hold_buf;
            pc_next    = pc_reg + PC_STEP;
            state_next = FETCH;
          end else begin
            hold = 1'b1;
          end
        end
        DISCARD: begin
          if (imem_ack) state_next = FETCH;
        end
        default: state_next = FETCH;
      endcase
    end
    vld_next = !flush && (load || (hold && valid));
  end

  // FSM, PC, request handshake and bubble counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= FETCH;
      pc_reg       <= RESET_PC;
      addr_reg     <= RESET_PC;
      req_reg      <= 1'b0;
      bubble_count <= 16'd0;
    end else begin
      state   <= state_next;
      pc_reg  <= pc_next;
      req_reg <= (state_next != HOLD);
      // While discarding, the old address must stay on the bus until its ack.
      if (state_next != DISCARD) addr_reg <= pc_next;
      if (!vld_next) bubble_count <= sat_inc16(bubble_count);
    end
  end

  // Word fetched while decode is frozen waits here until release.
  always_ff @(posedge clk) begin
    if (hold_capture) hold_buf <= imem_rdata;
  end

  assign imem_req  = req_reg;
  assign imem_addr = addr_reg;

  if_id_pipe_reg #(
    .ADDRESS_LEN    (ADDRESS_LEN),
    .INSTRUCTION_LEN(INSTRUCTION_LEN)
  ) u_if_id (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .load       (load),
    .hold       (hold),
    .load_pc    (pc_reg + PC_STEP),
    .load_instr (load_instr),
    .pc         (PC),
    .instruction(instruction),
    .valid      (valid)
  );

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register; sits directly upstream of the decode stage.
- Owns the PC and issues one-outstanding-request fetches to instruction memory over a req/ack handshake.
- Presents {PC+4, instruction, valid} to decode; honours the hazard freeze and the execute-stage branch redirect.

Parameters:
ADDRESS_LEN, 32, PC and address width (matches `ADDRESS_LEN)
INSTRUCTION_LEN, 32, instruction width (matches `INSTRUCTION_LEN)
RESET_PC, 0, PC value loaded on reset
PC_STEP, 4, byte increment per sequential fetch

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-low reset
freeze  in  1  hazard stall from hazard unit; hold IF/ID contents and PC
branch_taken  in  1  one-cycle redirect pulse from execute stage
branch_addr  in  ADDRESS_LEN  redirect target
imem_req  out  1  fetch request; held high until imem_ack
imem_addr  out  ADDRESS_LEN  fetch address; stable while imem_req=1
imem_ack  in  1  one-cycle pulse; imem_rdata valid this cycle
imem_rdata  in  INSTRUCTION_LEN  fetched word
PC  out  ADDRESS_LEN  registered PC+PC_STEP of the presented instruction
instruction  out  INSTRUCTION_LEN  registered instruction to decode
valid  out  1  registered; 1 = instruction is real, 0 = bubble
bubble_count  out  16  saturating count of cycles with valid=0 after reset

Behaviour:
- Reset (rst=0, async): pc_reg=RESET_PC, state=FETCH, PC=0, instruction=0, valid=0, bubble_count=0, hold buffer empty, imem_req=0 while rst=0.
- States: FETCH, HOLD, DISCARD.
- FETCH:
  - imem_req=1, imem_addr=pc_reg.
  - On imem_ack with freeze=0: IF/ID <= {pc_reg+PC_STEP, imem_rdata, 1}; pc_reg += PC_STEP; stay in FETCH.
  - On imem_ack with freeze=1: data goes to the hold buffer; IF/ID unchanged; go to HOLD.
  - No ack, freeze=0: IF/ID <= {0, 0, 0} (bubble).
  - No ack, freeze=1: IF/ID unchanged.
- HOLD:
  - imem_req=0.
  - When freeze=0: IF/ID <= buffer contents with valid=1; pc_reg += PC_STEP; go to FETCH.
- DISCARD:
  - imem_req=1 with the old address (the handshake forbids changing the address mid-request).
  - On imem_ack: drop the data and go to FETCH. IF/ID stays bubble.
- branch_taken has priority over freeze and ack. In the same cycle:
  - pc_reg <= branch_addr; IF/ID <= bubble (flush); hold buffer cleared.
  - From FETCH without ack: go to DISCARD. From FETCH with ack: data dropped, stay in FETCH. From HOLD: go to FETCH. From DISCARD: stay in DISCARD, target updated.
  - Consecutive pulses: the last target wins.
- Sequential-fetch latency: ack in cycle N gives valid=1 at outputs after edge N (one register stage). Zero-wait memory (ack every cycle) sustains 1 instruction/cycle.
- PC arithmetic is modulo 2^ADDRESS_LEN; wrap from 0xFFFFFFFC to 0 is silent.
- bubble_count increments on every edge where registered valid becomes/stays 0 (excluding reset) and saturates at 0xFFFF.
- Async reset mid-request: imem_req drops immediately. The memory must tolerate an abandoned request; a stray ack in the first cycle after reset is accepted as normal fetch data for RESET_PC only if imem_req=1 that cycle.

Decomposition:
- Shared defines (existing defines file): ADDRESS_LEN, INSTRUCTION_LEN, fetch state encoding (FETCH=2'd0, HOLD=2'd1, DISCARD=2'd2), bubble encoding constant (all zeros).
- One sub-module: if_id_pipe_reg (PC/instruction/valid register with freeze-hold and flush-to-bubble). FSM, PC, hold buffer and counter stay in the top.

Test Plan:
- Reset then ack every cycle with rdata=0xE3A01005, 0xE2811001 -> valid=1 with PC=4 then PC=8, instructions in order, bubble_count=1 (first cycle).
- freeze=1 for 3 cycles while ack arrives with 0xE0822003 -> IF/ID holds prior word; state HOLD, imem_req=0; on release instruction=0xE0822003 next cycle, pc_reg advances by exactly 4.
- Memory with 2-cycle wait; branch_taken, branch_addr=0x100 in the cycle after req -> imem_addr stays old until ack, that data dropped, next imem_addr=0x100, valid=0 throughout, first valid PC=0x104.
- branch_taken same cycle as freeze=1 and ack -> IF/ID flushed to valid=0/instruction=0, next fetch at branch_addr.
- branch_addr=0xFFFFFFFC, zero-wait memory -> PC output 0x00000000, next imem_addr=0.
- Assert rst low mid-request in DISCARD -> all outputs zero immediately, imem_req=0; after release, fetch at RESET_PC.
